// File: rtl/alu_operand_stage_if.sv
// Bus bundle between alu_operand_stage and its environment (host, instruction source, combinational alu).
// The master side drives instructions, register preloads and the alu's result/flags.
interface alu_operand_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        init_we;
    logic        init_addr;
    logic [31:0] init_data;
    logic [31:0] alu_instr;
    logic [31:0] alu_regA;
    logic [31:0] alu_regB;
    logic [31:0] alu_result;
    logic [2:0]  alu_flags;
    logic [31:0] regA_q;
    logic [31:0] regB_q;
    logic        retire_valid;
    logic [2:0]  retire_flags;
    logic [2:0]  sticky_flags;
    logic        busy;
    logic        halted;

    modport master (
        output in_valid, in_instr, init_we, init_addr, init_data, alu_result, alu_flags,
        input  in_ready, alu_instr, alu_regA, alu_regB, regA_q, regB_q,
               retire_valid, retire_flags, sticky_flags, busy, halted
    );

    modport slave (
        input  in_valid, in_instr, init_we, init_addr, init_data, alu_result, alu_flags,
        output in_ready, alu_instr, alu_regA, alu_regB, regA_q, regB_q,
               retire_valid, retire_flags, sticky_flags, busy, halted
    );
endinterface

// File: rtl/alu_operand_stage.sv
// Issue/writeback stage around a combinational MIPS alu: instruction FIFO, 2-entry register file,
// one retire per 2 cycles. Define ALU_STAGE_OVF_HALT_EN to halt on a trapping overflow until reset.
module alu_operand_stage #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_REGA = 32'd0,
    parameter logic [31:0] RESET_REGB = 32'd0
) (
    input logic           clk,
    input logic           rst,
    alu_operand_stage_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;

    typedef enum logic [1:0] {IDLE, EXEC, WB, HALT} state_t;

    state_t             state_q, state_d;
    logic [31:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               full, empty, push, pop;
    logic [31:0]        instr_q, result_q, reg_a_q, reg_b_q;
    logic [2:0]         flags_q, sticky_q;
    logic               retire_valid, halt_take, wb_en, wb_to_b, wb_we;
    logic [2:0]         retire_flags;

    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign push  = bus.in_valid && !full;

`ifdef ALU_STAGE_OVF_HALT_EN
    assign halt_take = flags_q[0];
`else
    assign halt_take = 1'b0;
`endif

    // NOTE: the FIFO storage has no reset; only the pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bus.in_instr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty) state_d = EXEC;
            EXEC:    state_d = WB;
            WB: begin
                if (halt_take)   state_d = HALT;
                else if (!empty) state_d = EXEC;
                else             state_d = IDLE;
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        retire_valid = 1'b0;
        retire_flags = 3'b000;
        pop          = 1'b0;
        case (state_q)
            IDLE: pop = !empty;
            WB: begin
                retire_valid = 1'b1;
                retire_flags = flags_q;
                pop          = !empty && !halt_take;
            end
            default: ;
        endcase
    end

    // Destination: R-type writes rd, immediate ALU ops write rt, everything else writes nothing.
    always_comb begin
        wb_en   = 1'b0;
        wb_to_b = 1'b0;
        case (instr_q[31:26])
            OP_RTYPE: begin
                wb_en   = 1'b1;
                wb_to_b = (instr_q[15:11] != 5'd0);
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                wb_en   = 1'b1;
                wb_to_b = (instr_q[20:16] != 5'd0);
            end
            default: ;
        endcase
    end

    assign wb_we = retire_valid && wb_en && !flags_q[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q  <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            if (pop) instr_q <= fifo_mem[rd_ptr];
            if (state_q == EXEC) begin
                result_q <= bus.alu_result;
                flags_q  <= bus.alu_flags;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_a_q  <= RESET_REGA;
            reg_b_q  <= RESET_REGB;
            sticky_q <= '0;
        end else begin
            if (bus.init_we && !bus.init_addr) reg_a_q <= bus.init_data;
            if (bus.init_we &&  bus.init_addr) reg_b_q <= bus.init_data;
            // NOTE: the writeback is assigned after the preload, so the later non-blocking write wins.
            if (wb_we && !wb_to_b) reg_a_q <= result_q;
            if (wb_we &&  wb_to_b) reg_b_q <= result_q;
            if (retire_valid) sticky_q <= sticky_q | flags_q;
        end
    end

    assign bus.in_ready     = !full;
    assign bus.alu_instr    = instr_q;
    assign bus.alu_regA     = reg_a_q;
    assign bus.alu_regB     = reg_b_q;
    assign bus.regA_q       = reg_a_q;
    assign bus.regB_q       = reg_b_q;
    assign bus.retire_valid = retire_valid;
    assign bus.retire_flags = retire_flags;
    assign bus.sticky_flags = sticky_q;
    assign bus.busy         = (state_q != IDLE) || !empty;
    assign bus.halted       = (state_q == HALT);
endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: a behavioural alu drives the DUT's alu inputs, and a
// queue-based sequential model of the instruction stream predicts retire flags and register state.
module tb_alu_operand_stage;
    localparam int          FIFO_DEPTH = 4;
    localparam logic [31:0] RESET_A    = 32'd0;
    localparam logic [31:0] RESET_B    = 32'd0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_operand_stage_if bus ();

    alu_operand_stage #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .RESET_REGA (RESET_A),
        .RESET_REGB (RESET_B)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks  = 0;
    int n_pass    = 0;
    int n_retired = 0;

    logic [31:0] exp_q[$];
    logic [31:0] m_a, m_b;
    logic [2:0]  m_sticky;
    bit          pend_v, pend_we, pend_b, last_push;
    logic [31:0] pend_data;
    logic [2:0]  pend_flags;

    // Environment alu: returns {zero, neg, ovf, result}; neg is the true sign, so it flips on overflow.
    function automatic logic [34:0] alu_model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r, imm_s, imm_z;
        logic        ovf;
        imm_s = {{16{ins[15]}}, ins[15:0]};
        imm_z = {16'd0, ins[15:0]};
        ovf   = 1'b0;
        r     = 32'd0;
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h20: begin r = a + b; ovf = (a[31] == b[31]) && (r[31] != a[31]); end
                6'h21: r = a + b;
                6'h22: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); end
                6'h23: r = a - b;
                6'h24: r = a & b;
                6'h25: r = a | b;
                6'h26: r = a ^ b;
                6'h2a: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                default: r = 32'd0;
            endcase
            6'h08: begin r = a + imm_s; ovf = (a[31] == imm_s[31]) && (r[31] != a[31]); end
            6'h09: r = a + imm_s;
            6'h0a: r = ($signed(a) < $signed(imm_s)) ? 32'd1 : 32'd0;
            6'h0b: r = (a < imm_s) ? 32'd1 : 32'd0;
            6'h0c: r = a & imm_z;
            6'h0d: r = a | imm_z;
            6'h0e: r = a ^ imm_z;
            6'h04, 6'h05: r = a - b;
            6'h23, 6'h2b: r = a + imm_s;
            default: r = 32'd0;
        endcase
        return {(r == 32'd0), r[31] ^ ovf, ovf, r};
    endfunction

    assign {bus.alu_flags, bus.alu_result} = alu_model(bus.alu_instr, bus.alu_regA, bus.alu_regB);

    function automatic void wb_target(input logic [31:0] ins, output bit we, output bit to_b);
        we   = 1'b0;
        to_b = 1'b0;
        case (ins[31:26])
            6'h00: begin we = 1'b1; to_b = (ins[15:11] != 5'd0); end
            6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e: begin we = 1'b1; to_b = (ins[20:16] != 5'd0); end
            default: ;
        endcase
    endfunction

    // One clock: capture pre-edge inputs, advance the model, compare what changed.
    task automatic step();
        bit          do_push, do_init, do_rst, i_addr, we, to_b;
        logic [31:0] p_instr, i_data, ins;
        logic [34:0] res;
        do_push = bus.in_valid && bus.in_ready;
        p_instr = bus.in_instr;
        do_init = bus.init_we;
        i_addr  = bus.init_addr;
        i_data  = bus.init_data;
        do_rst  = rst;
        @(posedge clk);
        #1;
        last_push = do_push && !do_rst;
        if (do_rst) begin
            exp_q.delete();
            m_a = RESET_A; m_b = RESET_B; m_sticky = 3'b000; pend_v = 1'b0;
        end else begin
            if (do_push) exp_q.push_back(p_instr);
            if (do_init) begin
                if (i_addr) m_b = i_data; else m_a = i_data;
            end
            if (pend_v) begin
                if (pend_we && pend_b)  m_b = pend_data;
                if (pend_we && !pend_b) m_a = pend_data;
                m_sticky = m_sticky | pend_flags;
            end
            if (do_init || pend_v) begin
                n_checks++;
                if (bus.regA_q !== m_a || bus.regB_q !== m_b || bus.sticky_flags !== m_sticky)
                    $display("FAIL reg_state: got A=%h B=%h sticky=%b, want A=%h B=%h sticky=%b",
                             bus.regA_q, bus.regB_q, bus.sticky_flags, m_a, m_b, m_sticky);
                else n_pass++;
            end
            pend_v = 1'b0;
        end
        if (bus.retire_valid === 1'b1) begin
            n_retired++;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL retire_unexpected: got retire with flags=%b, want no retire", bus.retire_flags);
            end else begin
                ins = exp_q.pop_front();
                res = alu_model(ins, m_a, m_b);
                wb_target(ins, we, to_b);
                if (bus.retire_flags !== res[34:32])
                    $display("FAIL retire_flags: instr=%h got %b want %b", ins, bus.retire_flags, res[34:32]);
                else n_pass++;
                pend_v     = 1'b1;
                pend_we    = we && !res[32];
                pend_b     = to_b;
                pend_data  = res[31:0];
                pend_flags = res[34:32];
            end
        end
    endtask

    task automatic do_init(input bit addr, input logic [31:0] data);
        bus.init_we = 1'b1; bus.init_addr = addr; bus.init_data = data;
        step();
        bus.init_we = 1'b0;
    endtask

    task automatic push_instr(input logic [31:0] ins);
        bus.in_valid = 1'b1; bus.in_instr = ins;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || bus.busy !== 1'b0) && n < budget) begin
            step();
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0 || bus.busy !== 1'b0)
            $display("FAIL drain_timeout: got %0d pending busy=%b after %0d cycles, want 0 pending busy=0",
                     exp_q.size(), bus.busy, n);
        else n_pass++;
    endtask

    task automatic wait_retire(input int budget, output int cycles);
        cycles = 0;
        while (bus.retire_valid !== 1'b1 && cycles < budget) begin
            step();
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (bus.regA_q !== RESET_A || bus.regB_q !== RESET_B || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 ||
            bus.sticky_flags !== 3'b000 || bus.retire_valid !== 1'b0 || bus.halted !== 1'b0 || bus.alu_instr !== 32'd0)
            $display("FAIL reset_state: got A=%h B=%h rdy=%b busy=%b sticky=%b ret=%b halt=%b ai=%h, want %h %h 1 0 000 0 0 0",
                     bus.regA_q, bus.regB_q, bus.in_ready, bus.busy, bus.sticky_flags, bus.retire_valid,
                     bus.halted, bus.alu_instr, RESET_A, RESET_B);
        else n_pass++;
    endtask

    task automatic test_add_latency();
        int lat;
        do_init(1'b0, 32'd5);
        do_init(1'b1, 32'd7);
        push_instr(32'h00010820);
        wait_retire(10, lat);
        lat = lat + 1;
        n_checks++;
        if (lat != 3) $display("FAIL add_latency: got %0d edges to retire, want 3", lat);
        else n_pass++;
        n_checks++;
        if (bus.retire_flags !== 3'b000) $display("FAIL add_flags: got %b want 000", bus.retire_flags);
        else n_pass++;
        step();
        n_checks++;
        if (bus.regB_q !== 32'd12 || bus.retire_valid !== 1'b0)
            $display("FAIL add_writeback: got B=%0d ret=%b, want B=12 ret=0", bus.regB_q, bus.retire_valid);
        else n_pass++;
        wait_idle(20);
    endtask

    task automatic test_addi();
        int c;
        do_init(1'b0, 32'd5);
        push_instr(32'h2000FFFF);
        wait_retire(10, c);
        n_checks++;
        if (bus.retire_flags !== 3'b000) $display("FAIL addi_flags: got %b want 000", bus.retire_flags);
        else n_pass++;
        step();
        n_checks++;
        if (bus.regA_q !== 32'd4) $display("FAIL addi_result: got A=%0d want 4", bus.regA_q);
        else n_pass++;
        wait_idle(20);
    endtask

    task automatic test_overflow();
        int c;
        do_init(1'b0, 32'h7FFFFFFF);
        do_init(1'b1, 32'd1);
        push_instr(32'h00010020);
        wait_retire(10, c);
        n_checks++;
        if (bus.retire_flags !== 3'b001) $display("FAIL ovf_flags: got %b want 001", bus.retire_flags);
        else n_pass++;
        step();
        n_checks++;
        if (bus.regA_q !== 32'h7FFFFFFF || bus.sticky_flags[0] !== 1'b1)
            $display("FAIL ovf_suppress: got A=%h sticky=%b, want A=7fffffff sticky[0]=1", bus.regA_q, bus.sticky_flags);
        else n_pass++;
`ifdef ALU_STAGE_OVF_HALT_EN
        n_checks++;
        if (bus.halted !== 1'b1) $display("FAIL ovf_halted: got %b want 1", bus.halted);
        else n_pass++;
        c = n_retired;
        push_instr(32'h00010821);
        for (int i = 0; i < 12; i++) step();
        n_checks++;
        if (n_retired != c || bus.halted !== 1'b1)
            $display("FAIL halt_holds: got %0d retires halted=%b, want 0 retires halted=1", n_retired - c, bus.halted);
        else n_pass++;
        test_reset();
`else
        n_checks++;
        if (bus.halted !== 1'b0) $display("FAIL ovf_no_halt: got %b want 0", bus.halted);
        else n_pass++;
        wait_idle(20);
`endif
    endtask

    task automatic test_fifo_full();
        logic [31:0] words [10];
        int idx = 0, cyc = 0, r0;
        bit saw_full = 1'b0;
        for (int i = 0; i < 10; i++) begin
            case (i % 3)
                0:       words[i] = {6'h00, 5'd0, 5'd1, 5'd1, 5'(i), 6'h21};
                1:       words[i] = {6'h00, 5'd0, 5'd1, 5'd1, 5'(i), 6'h23};
                default: words[i] = {6'h0e, 5'd0, 5'd1, 16'(i * 16'h111)};
            endcase
        end
        do_init(1'b0, $urandom());
        do_init(1'b1, $urandom());
        r0 = n_retired;
        bus.in_valid = 1'b1;
        while (idx < 10 && cyc < 200) begin
            bus.in_instr = words[idx];
            step();
            if (last_push) idx++;
            cyc++;
            if (bus.in_ready === 1'b0) saw_full = 1'b1;
            n_checks++;
            if ((bus.in_ready === 1'b1 && exp_q.size() > FIFO_DEPTH) ||
                (bus.in_ready !== 1'b1 && (exp_q.size() < FIFO_DEPTH || exp_q.size() > FIFO_DEPTH + 1)))
                $display("FAIL fifo_ready: got in_ready=%b with %0d outstanding, want ready only below depth %0d",
                         bus.in_ready, exp_q.size(), FIFO_DEPTH);
            else n_pass++;
        end
        bus.in_valid = 1'b0;
        wait_idle(100);
        n_checks++;
        if (n_retired - r0 != 10 || !saw_full)
            $display("FAIL fifo_stream: got %0d retires saw_full=%b, want 10 retires saw_full=1", n_retired - r0, saw_full);
        else n_pass++;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom();
`ifdef ALU_STAGE_OVF_HALT_EN
        int sel = $urandom_range(0, 13);
`else
        int sel = $urandom_range(0, 15);
`endif
        case (sel)
            0:  begin w[31:26] = 6'h00; w[5:0] = 6'h21; end
            1:  begin w[31:26] = 6'h00; w[5:0] = 6'h23; end
            2:  begin w[31:26] = 6'h00; w[5:0] = 6'h24; end
            3:  begin w[31:26] = 6'h00; w[5:0] = 6'h25; end
            4:  begin w[31:26] = 6'h00; w[5:0] = 6'h26; end
            5:  begin w[31:26] = 6'h00; w[5:0] = 6'h2a; end
            6:  w[31:26] = 6'h09;
            7:  w[31:26] = 6'h0c;
            8:  w[31:26] = 6'h0d;
            9:  w[31:26] = 6'h0e;
            10: w[31:26] = 6'h0a;
            11: w[31:26] = 6'h0b;
            12: w[31:26] = 6'h04;
            13: w[31:26] = 6'h2b;
            14: begin w[31:26] = 6'h00; w[5:0] = 6'h20; end
            default: w[31:26] = 6'h08;
        endcase
        return w;
    endfunction

    task automatic test_random();
        int sent = 0, cyc = 0;
        do_init(1'b0, $urandom());
        do_init(1'b1, $urandom());
        while (sent < 60 && cyc < 2000) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_instr = rand_instr();
            step();
            if (last_push) sent++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        wait_idle(200);
    endtask

    task automatic test_branch_and_reset();
        int c;
        do_init(1'b0, 32'd5);
        do_init(1'b1, 32'd7);
        c = n_retired;
        push_instr(32'h10010001);
        wait_idle(20);
        n_checks++;
        if (n_retired - c != 1 || bus.regA_q !== 32'd5 || bus.regB_q !== 32'd7)
            $display("FAIL beq_nowrite: got %0d retires A=%0d B=%0d, want 1 retire A=5 B=7",
                     n_retired - c, bus.regA_q, bus.regB_q);
        else n_pass++;
        push_instr(32'h00010820);
        wait_retire(10, c);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.regB_q !== RESET_B || bus.regA_q !== RESET_A || bus.retire_valid !== 1'b0)
            $display("FAIL reset_in_wb: got busy=%b A=%h B=%h ret=%b, want busy=0 A=%h B=%h ret=0",
                     bus.busy, bus.regA_q, bus.regB_q, bus.retire_valid, RESET_A, RESET_B);
        else n_pass++;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'd0;
        bus.init_we   = 1'b0;
        bus.init_addr = 1'b0;
        bus.init_data = 32'd0;
        m_a = RESET_A; m_b = RESET_B; m_sticky = 3'b000;
        pend_v = 1'b0; pend_we = 1'b0; pend_b = 1'b0; last_push = 1'b0;
        pend_data = 32'd0; pend_flags = 3'b000;
        test_reset();
        test_add_latency();
        test_addi();
        test_overflow();
        test_fifo_full();
        test_random();
        test_branch_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
